// File: rtl/hps_gpio_ext.sv
// hps_gpio_ext: Avalon-MM GPIO block with an input synchroniser, edge capture
// with write-1-to-clear, per-bit output enable and a level interrupt.
module hps_gpio_ext #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      EDGE_MODE   = 0,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic [WIDTH-1:0] oe,
   output logic             irq
);

   localparam logic [2:0] ADDR_DATA   = 3'd0;
   localparam logic [2:0] ADDR_DIR    = 3'd1;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;
   localparam logic [2:0] ADDR_OUTSET = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR = 3'd5;

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] in_prev;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] edge_clr;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [31:0]      rd_mux;

   assign wr_en   = chipselect & ~write_n;
   assign wr_data = writedata[WIDTH-1:0];
   assign in_sync = sync_q[SYNC_STAGES-1];

   // Input synchroniser chain; the last stage is the metastability-safe in_sync.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // One-cycle history of in_sync used as the reference for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) in_prev <= '0;
      else          in_prev <= in_sync;
   end

   // Per-bit edge qualifier selected by EDGE_MODE (0 rise, 1 fall, else any).
   always_comb begin
      edge_det = in_sync ^ in_prev;
      case (EDGE_MODE)
         0:       edge_det = in_sync & ~in_prev;
         1:       edge_det = ~in_sync & in_prev;
         default: edge_det = in_sync ^ in_prev;
      endcase
   end

   // Bits to clear in the capture register from a W1C write this cycle.
   always_comb begin
      edge_clr = '0;
      if (wr_en && (address == ADDR_EDGE)) edge_clr = wr_data;
   end

   // Output data, direction and mask registers loaded from the bus.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_port <= OUT_RESET;
         oe       <= '0;
         irq_mask <= '0;
      end else if (wr_en) begin
         case (address)
            ADDR_DATA:   out_port <= wr_data;
            ADDR_DIR:    oe       <= wr_data;
            ADDR_MASK:   irq_mask <= wr_data;
            ADDR_OUTSET: out_port <= out_port | wr_data;
            ADDR_OUTCLR: out_port <= out_port & ~wr_data;
            default:     ;
         endcase
      end
   end

   // Edge capture: clear is applied first so a coincident new edge keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) edge_cap <= '0;
      else          edge_cap <= (edge_cap & ~edge_clr) | edge_det;
   end

   // Level interrupt straight from the capture and mask registers.
   assign irq = |(edge_cap & irq_mask);

   // Read mux; unused upper bits and write-only/reserved addresses return zero.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA: rd_mux[WIDTH-1:0] = in_sync;
         ADDR_DIR:  rd_mux[WIDTH-1:0] = oe;
         ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_cap;
         default:   rd_mux = '0;
      endcase
   end

   // Registered read data, refreshed every cycle regardless of chipselect.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

endmodule

// File: tb/tb_hps_gpio_ext.sv
// tb_hps_gpio_ext: two instances (rising and any-edge capture) driven from one
// bus, checked against a queue-based reference model through a scoreboard.
module tb_hps_gpio_ext;

   localparam int S = 2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] readdata0, readdata2;
   logic [7:0]  out0, out2, oe0, oe2;
   logic        irq0, irq2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hps_gpio_ext #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(0), .OUT_RESET(8'hA5)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata0),
      .in_port(in_port), .out_port(out0), .oe(oe0), .irq(irq0));

   hps_gpio_ext #(.WIDTH(8), .SYNC_STAGES(S), .EDGE_MODE(2), .OUT_RESET(8'hA5)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata2),
      .in_port(in_port), .out_port(out2), .oe(oe2), .irq(irq2));

   typedef struct packed {
      logic [31:0] rd0;
      logic [31:0] rd2;
      logic [7:0]  outp;
      logic [7:0]  oev;
      logic        irq0;
      logic        irq2;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] hist[$];
   logic [7:0] m_out, m_oe, m_mask, m_cap0, m_cap2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] rdval(input logic [2:0] a, input logic [7:0] syncv,
                                         input logic [7:0] oev, input logic [7:0] maskv,
                                         input logic [7:0] capv);
      case (a)
         3'd0:    return {24'h0, syncv};
         3'd1:    return {24'h0, oev};
         3'd2:    return {24'h0, maskv};
         3'd3:    return {24'h0, capv};
         default: return 32'h0;
      endcase
   endfunction

   // Reference model: pin history queue, newest sample first; in_sync is the
   // pin seen S edges ago and the edge reference is the one before that.
   always @(posedge clk) begin
      exp_t       e;
      logic [7:0] cur, old, wd;
      logic       wr;
      if (!reset_n) begin
         m_out = 8'hA5; m_oe = 8'h00; m_mask = 8'h00; m_cap0 = 8'h00; m_cap2 = 8'h00;
         hist = {};
         for (int i = 0; i <= S; i++) hist.push_back(8'h00);
         e.rd0 = 32'h0;
         e.rd2 = 32'h0;
      end else begin
         cur = hist[S-1];
         old = hist[S];
         wr  = chipselect && !write_n;
         wd  = writedata[7:0];
         e.rd0 = rdval(address, cur, m_oe, m_mask, m_cap0);
         e.rd2 = rdval(address, cur, m_oe, m_mask, m_cap2);
         if (wr) begin
            case (address)
               3'd0: m_out  = wd;
               3'd1: m_oe   = wd;
               3'd2: m_mask = wd;
               3'd3: begin m_cap0 = m_cap0 & ~wd; m_cap2 = m_cap2 & ~wd; end
               3'd4: m_out  = m_out | wd;
               3'd5: m_out  = m_out & ~wd;
               default: ;
            endcase
         end
         m_cap0 = m_cap0 | (cur & ~old);
         m_cap2 = m_cap2 | (cur ^ old);
         hist.push_front(in_port);
         void'(hist.pop_back());
      end
      e.outp = m_out;
      e.oev  = m_oe;
      e.irq0 = |(m_cap0 & m_mask);
      e.irq2 = |(m_cap2 & m_mask);
      sb_q.push_back(e);
   end

   // Monitor: compares DUT outputs against the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() == 0) begin
         if ($time > 20) chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         chk("readdata0", readdata0, e.rd0);
         chk("readdata2", readdata2, e.rd2);
         chk("out_port0", {24'h0, out0}, {24'h0, e.outp});
         chk("out_port2", {24'h0, out2}, {24'h0, e.outp});
         chk("oe0", {24'h0, oe0}, {24'h0, e.oev});
         chk("oe2", {24'h0, oe2}, {24'h0, e.oev});
         chk("irq0", {31'h0, irq0}, {31'h0, e.irq0});
         chk("irq2", {31'h0, irq2}, {31'h0, e.irq2});
      end
   end

   task automatic cyc(input logic [2:0] a, input logic c, input logic w, input logic [31:0] d);
      address = a; chipselect = c; write_n = w; writedata = d;
      @(posedge clk); #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cyc(a, 1'b1, 1'b0, d);
   endtask

   task automatic rd(input logic [2:0] a);
      cyc(a, 1'b1, 1'b1, 32'h0);
   endtask

   task automatic idle();
      cyc(3'd0, 1'b0, 1'b1, 32'hDEADBEEF);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset_n = 1'b0;
      #1;
      chk("rst_out", {24'h0, out0}, 32'hA5);
      chk("rst_oe", {24'h0, oe0}, 32'h0);
      chk("rst_irq0", {31'h0, irq0}, 32'h0);
      chk("rst_irq2", {31'h0, irq2}, 32'h0);
      chk("rst_rd", readdata0, 32'h0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = 32'h0; in_port = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("init_out", {24'h0, out0}, 32'hA5);
      chk("init_oe", {24'h0, oe0}, 32'h0);
      chk("init_irq", {31'h0, irq0}, 32'h0);
      chk("init_rd", readdata0, 32'h0);
      reset_n = 1'b1;
      idle();

      // Output register: load, set, clear; OUTSET reads as zero.
      wr(3'd0, 32'h0000000F); chk("data_wr", {24'h0, out0}, 32'h0F);
      wr(3'd4, 32'h00000030); chk("outset", {24'h0, out0}, 32'h3F);
      wr(3'd5, 32'h00000003); chk("outclr", {24'h0, out0}, 32'h3C);
      rd(3'd4);               chk("rd_outset", readdata0, 32'h0);
      cyc(3'd0, 1'b0, 1'b0, 32'h0); chk("no_cs_write", {24'h0, out0}, 32'h3C);
      wr(3'd6, 32'hFFFFFFFF); chk("reserved_wr", {24'h0, out0}, 32'h3C);

      // Rising edge on bit3 captured two edges later; irq follows the mask.
      in_port = 8'h08;
      idle(); idle(); idle();
      chk("irq_unmasked", {31'h0, irq0}, 32'h0);
      wr(3'd2, 32'h00000008); chk("irq_masked", {31'h0, irq0}, 32'h1);
      rd(3'd3);               chk("cap_rise", readdata0, 32'h08);

      // W1C coincident with a fresh rising edge leaves the bit set.
      in_port = 8'h00;
      idle(); idle(); idle();
      in_port = 8'h08;
      idle(); idle();
      wr(3'd3, 32'h00000008); chk("w1c_vs_edge", {31'h0, irq0}, 32'h1);
      rd(3'd3);               chk("cap_kept", readdata0, 32'h08);
      wr(3'd3, 32'h00000008); chk("w1c_clear", {31'h0, irq0}, 32'h0);

      // Direction register readback and upper-bit masking.
      wr(3'd1, 32'h000000F0); chk("oe_wr", {24'h0, oe0}, 32'hF0);
      rd(3'd1);               chk("rd_dir", readdata0, 32'h000000F0);
      wr(3'd1, 32'hFFFFFFFF);
      rd(3'd1);               chk("rd_dir_full", readdata0, 32'h000000FF);

      // Any-edge mode: a 4-cycle pulse on bit0 captures on rise and on fall.
      in_port = 8'h00;
      idle(); idle(); idle(); idle();
      wr(3'd3, 32'h000000FF);
      wr(3'd2, 32'h00000001);
      in_port = 8'h01;
      idle(); idle(); idle();
      chk("any_rise", {31'h0, irq2}, 32'h1);
      chk("rise_rise", {31'h0, irq0}, 32'h1);
      wr(3'd3, 32'h00000001);
      chk("any_cleared", {31'h0, irq2}, 32'h0);
      in_port = 8'h00;
      idle(); idle(); idle();
      chk("any_fall", {31'h0, irq2}, 32'h1);
      chk("rise_nofall", {31'h0, irq0}, 32'h0);

      // Pin held high across reset produces one capture after release.
      in_port = 8'h02;
      idle();
      do_reset();
      idle(); idle(); idle();
      rd(3'd3);
      chk("post_rst_cap0", readdata0, 32'h02);
      chk("post_rst_cap2", readdata2, 32'h02);

      // Randomised traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         in_port = in_port ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
         cyc(3'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), $urandom);
      end
      idle(); idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hps_gpio_ext.md
HPS_GPIO_EXT -- requirements
Module: hps_gpio_ext

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, legal 1..32: number of GPIO bits.
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, legal 2..3: input synchroniser depth.
REQ-003 SHALL provide parameter EDGE_MODE, default 0: 0 rising, 1 falling, 2 any edge.
REQ-004 SHALL provide parameter OUT_RESET, default 0: WIDTH-bit reset value of the output data register.
REQ-005 SHALL provide clk  input  1  rising-edge clock for all state.
REQ-006 SHALL provide reset_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL provide address  input  3  Avalon-MM word address.
REQ-008 SHALL provide chipselect  input  1  slave select.
REQ-009 SHALL provide write_n  input  1  active-low write strobe.
REQ-010 SHALL provide writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-011 SHALL provide readdata  output  32  registered read data.
REQ-012 SHALL provide in_port  input  WIDTH  asynchronous pin inputs.
REQ-013 SHALL provide out_port  output  WIDTH  output data register value.
REQ-014 SHALL provide oe  output  WIDTH  per-bit output enable, 1 = drive.
REQ-015 SHALL provide irq  output  1  active-high level interrupt.

Function
REQ-016 Register map SHALL be: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP, 4 OUTSET, 5 OUTCLR; 6..7 reserved.
REQ-017 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; no effect otherwise.
REQ-018 Write DATA SHALL load out_port from writedata[WIDTH-1:0].
REQ-019 Write OUTSET SHALL OR writedata into out_port; write OUTCLR SHALL AND out_port with ~writedata.
REQ-020 Write DIR SHALL load oe; write IRQ_MASK SHALL load the mask register.
REQ-021 Write EDGE_CAP SHALL clear each capture bit whose writedata bit is 1 (write-1-to-clear).
REQ-022 Writes to addresses 6..7 SHALL have no effect.
REQ-023 in_port SHALL pass through a SYNC_STAGES flop chain; sync output = in_sync.
REQ-024 A prev register SHALL hold in_sync delayed one cycle; edge per bit: rising in_sync&~prev, falling ~in_sync&prev, any XOR.
REQ-025 A detected edge SHALL set its EDGE_CAP bit on the same clk edge it is registered; bit holds until cleared.
REQ-026 Same-cycle edge detect and W1C on one bit: set SHALL win (bit ends 1).
REQ-027 Edge capture SHALL operate regardless of DIR and IRQ_MASK.
REQ-028 irq SHALL equal OR of (EDGE_CAP & IRQ_MASK), combinational from registers, no extra latency.
REQ-029 readdata SHALL update on every clk edge, independent of chipselect: 1-cycle read latency.
REQ-030 Read mux SHALL be: DATA -> in_sync; DIR -> oe; IRQ_MASK -> mask; EDGE_CAP -> capture; OUTSET/OUTCLR/6/7 -> 0.
REQ-031 readdata bits 31..WIDTH SHALL read 0.
REQ-032 Input latency: in_port stable before edge k SHALL appear in in_sync at edge k+SYNC_STAGES-1, EDGE_CAP at k+SYNC_STAGES, readdata(DATA) at k+SYNC_STAGES.
REQ-033 Read of EDGE_CAP in the same cycle as a W1C write SHALL return pre-write value.

Reset
REQ-034 On reset_n=0, asynchronously: out_port=OUT_RESET, oe=0, mask=0, EDGE_CAP=0, sync chain=0, prev=0, readdata=0, irq=0.
REQ-035 Reset mid-operation SHALL discard pending edges; a pin held high across reset release SHALL produce one rising edge capture (EDGE_MODE 0/2) SYNC_STAGES cycles after release.

Verification
REQ-036 Reset, WIDTH=8, OUT_RESET=8'hA5 -> out_port=A5, oe=00, irq=0, readdata=0.
REQ-037 Write DATA 0x0F, OUTSET 0x30, OUTCLR 0x03 -> out_port 0F, 3F, 3C; read DATA-less OUTSET address -> readdata 0.
REQ-038 EDGE_MODE 0, SYNC_STAGES 2, in_port bit3 0->1 before edge k -> EDGE_CAP=0x08 at k+2; irq=0 until IRQ_MASK=0x08 written, then irq=1 same cycle mask registers.
REQ-039 W1C EDGE_CAP 0x08 coincident with new rising edge on bit3 -> bit3 remains 1, irq stays 1.
REQ-040 Write DIR 0xF0 then read DIR -> readdata 0x000000F0 one cycle after address presented; writedata 0xFFFFFFFF to DIR with WIDTH=8 -> readdata 0x000000FF.
REQ-041 EDGE_MODE 2: pulse bit0 high 4 cycles -> capture set once on rise; after W1C, set again on fall.
